// File: rtl/pc_src_unit.sv
// pc_src_unit: next-PC source selector and PC register for the multicycle datapath.
// Picks one of NUM_SRC candidate buses, commits it to the PC on an unconditional or
// branch-taken request unless stalled, keeps the previous PC, and flags illegal selects.
// Optional feature macro: PC_SRC_ALIGN_CHECK_EN. When defined, a request whose selected
// target is not word aligned is refused and reported with a one-cycle misalign pulse.
module pc_src_unit #(
    parameter int               WIDTH    = 32,
    parameter int               NUM_SRC  = 4,
    parameter int               SEL_W    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [WIDTH*NUM_SRC-1:0] src_flat,
    input  logic [SEL_W-1:0]         control_signal,
    input  logic                     pc_write,
    input  logic                     pc_write_cond,
    input  logic                     zero,
    input  logic                     stall,
    output logic [WIDTH-1:0]         next_pc,
    output logic [WIDTH-1:0]         pc,
    output logic [WIDTH-1:0]         pc_prev,
    output logic                     pc_updated,
    output logic                     sel_err,
    output logic                     misalign
);

    // Packed view of the flat source bus: src[i] is source i.
    logic [NUM_SRC-1:0][WIDTH-1:0] src;
    logic [31:0]                   sel_ext;
    logic                          sel_legal;
    logic                          req;
    logic                          live_req;
    logic                          align_fault;
    logic                          commit;
    logic                          sel_bad;

    assign src       = src_flat;
    assign sel_ext   = 32'(control_signal);
    assign sel_legal = sel_ext < 32'(NUM_SRC);

    // Source mux; an out-of-range select yields zero rather than an aliased source.
    always_comb begin
        next_pc = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (sel_ext == 32'(i)) next_pc = src[i];
        end
    end

    // A branch request needs the zero flag; an unconditional write dominates it.
    assign req      = pc_write | (pc_write_cond & zero);
    // A stalled request is invisible: it can neither commit nor raise any flag.
    assign live_req = req & ~stall;

`ifdef PC_SRC_ALIGN_CHECK_EN
    assign align_fault = live_req & sel_legal & (next_pc[1:0] != 2'b00);
`else
    assign align_fault = 1'b0;
`endif

    assign commit  = live_req & sel_legal & ~align_fault;
    assign sel_bad = live_req & ~sel_legal;

    // PC, previous PC, commit pulse and sticky select error.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc         <= RESET_PC;
            pc_prev    <= RESET_PC;
            pc_updated <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            pc_updated <= commit;
            if (commit) begin
                pc      <= next_pc;
                pc_prev <= pc;
            end
            if (sel_bad) sel_err <= 1'b1;
        end
    end

`ifdef PC_SRC_ALIGN_CHECK_EN
    logic misalign_q;

    // Alignment fault pulse; exclusive with pc_updated because a fault blocks the commit.
    always_ff @(posedge clk) begin
        if (!reset_n) misalign_q <= 1'b0;
        else          misalign_q <= align_fault;
    end

    assign misalign = misalign_q;
`else
    assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_src_unit.sv
// tb_pc_src_unit: directed plus randomized stimulus against a behavioural PC model.
// The driver pushes the expected post-edge state into a queue; a separate monitor pops
// one entry per clock edge and compares it with what the DUT shows.
module tb_pc_src_unit;

    localparam int          WIDTH    = 32;
    localparam int          NUM_SRC  = 3;
    localparam int          SEL_W    = 2;
    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic                     clk = 1'b0;
    logic                     reset_n = 1'b0;
    logic [WIDTH*NUM_SRC-1:0] src_flat = '0;
    logic [SEL_W-1:0]         control_signal = '0;
    logic                     pc_write = 1'b0;
    logic                     pc_write_cond = 1'b0;
    logic                     zero = 1'b0;
    logic                     stall = 1'b0;
    logic [WIDTH-1:0]         next_pc;
    logic [WIDTH-1:0]         pc;
    logic [WIDTH-1:0]         pc_prev;
    logic                     pc_updated;
    logic                     sel_err;
    logic                     misalign;

    pc_src_unit #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .src_flat(src_flat),
        .control_signal(control_signal), .pc_write(pc_write),
        .pc_write_cond(pc_write_cond), .zero(zero), .stall(stall),
        .next_pc(next_pc), .pc(pc), .pc_prev(pc_prev), .pc_updated(pc_updated),
        .sel_err(sel_err), .misalign(misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] nxt;
        logic [31:0] pc;
        logic [31:0] prev;
        bit          upd;
        bit          err;
        bit          mis;
    } exp_t;

    exp_t        sbq[$];
    int          n_checks = 0;
    int          n_pass   = 0;

    // Reference model state
    logic [31:0] m_pc   = RESET_PC;
    logic [31:0] m_prev = RESET_PC;
    bit          m_err  = 0;
    logic [31:0] srcs [NUM_SRC];

`ifdef PC_SRC_ALIGN_CHECK_EN
    localparam bit ALIGN_ON = 1'b1;
`else
    localparam bit ALIGN_ON = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    endtask

    // Apply one cycle of stimulus at the falling edge and predict the state after the next rise.
    task automatic drive(input bit rst, input bit pw, input bit pwc, input bit z,
                         input bit st, input int sel);
        exp_t e;
        int   legal;
        bit   taken;
        @(negedge clk);
        reset_n        = ~rst;
        pc_write       = pw;
        pc_write_cond  = pwc;
        zero           = z;
        stall          = st;
        control_signal = SEL_W'(sel);
        for (int i = 0; i < NUM_SRC; i++) src_flat[i*WIDTH +: WIDTH] = srcs[i];

        legal = (sel < NUM_SRC);
        e.nxt = legal ? srcs[sel] : 32'h0;
        e.upd = 0;
        e.mis = 0;
        taken = (pw || (pwc && z)) && !st;
        if (rst) begin
            m_pc   = RESET_PC;
            m_prev = RESET_PC;
            m_err  = 0;
        end else if (taken) begin
            if (!legal)                              m_err = 1;
            else if (ALIGN_ON && (e.nxt % 4) != 0)   e.mis = 1;
            else begin
                m_prev = m_pc;
                m_pc   = e.nxt;
                e.upd  = 1;
            end
        end
        e.pc   = m_pc;
        e.prev = m_prev;
        e.err  = m_err;
        sbq.push_back(e);
    endtask

    // Monitor: one expected entry per rising edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                check("next_pc",    next_pc,          e.nxt);
                check("pc",         pc,               e.pc);
                check("pc_prev",    pc_prev,          e.prev);
                check("pc_updated", 32'(pc_updated),  32'(e.upd));
                check("sel_err",    32'(sel_err),     32'(e.err));
                check("misalign",   32'(misalign),    32'(e.mis));
                check("upd_mis_excl", 32'(pc_updated & misalign), 32'h0);
            end
        end
    end

    initial begin
        srcs[0] = 32'h3;
        srcs[1] = 32'h1;
        srcs[2] = 32'h10;

        // Reset held for two edges, with a write request that must be overridden.
        drive(1, 1, 0, 0, 0, 1);
        drive(1, 0, 0, 0, 0, 0);

        // Unconditional commits, then back-to-back with an unchanged value.
        drive(0, 1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 0, 2);
        drive(0, 1, 0, 0, 0, 2);
        drive(0, 1, 0, 0, 0, 1);

        // Branch not taken, taken, and both enables with zero low.
        drive(0, 0, 1, 0, 0, 2);
        drive(0, 0, 1, 1, 0, 2);
        drive(0, 1, 1, 0, 0, 1);

        // Stall for three cycles, then release onto an unaligned source.
        drive(0, 1, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 1, 0);
        drive(0, 1, 0, 0, 1, 3);
        drive(0, 1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);

        // Illegal select: no commit, sticky error, survives further legal commits.
        drive(0, 1, 0, 0, 0, 3);
        drive(0, 0, 0, 0, 0, 3);
        drive(0, 1, 0, 0, 0, 2);
        drive(0, 0, 0, 0, 0, 0);

        // Reset in the middle of a commit clears the error too.
        drive(1, 1, 0, 0, 0, 2);
        drive(0, 0, 0, 0, 0, 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(7, 0) == 0) begin
                for (int i = 0; i < NUM_SRC; i++) begin
                    srcs[i] = $urandom;
                    if ($urandom_range(1, 0) != 0) srcs[i][1:0] = 2'b00;
                end
            end
            drive($urandom_range(39, 0) == 0,
                  $urandom_range(2, 0) == 0, $urandom_range(1, 0) != 0,
                  $urandom_range(1, 0) != 0, $urandom_range(4, 0) == 0,
                  int'($urandom_range(3, 0)));
        end
        drive(0, 0, 0, 0, 0, 0);

        // Let the monitor drain, bounded by a cycle budget.
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        #2;
        check("queue_drained", 32'(sbq.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
